axi_wr_back_burst_issuer: RTL

- Consumes the read side of the master async write-back FIFO and drains it to memory as AXI4 INCR write bursts.
- Watches the FIFO read water level, pops words with r_en, issues AW, streams W beats and waits for B, one burst outstanding at a time.
- Lives entirely in the FIFO read clock domain.

---
 rtl/axi_wr_back_burst_issuer_pkg.sv | 41 ++++
 rtl/axi_wr_back_burst_issuer_skid_buf.sv | 72 +++++++
 rtl/axi_wr_back_burst_issuer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_back_burst_issuer_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_back_burst_issuer_pkg
// Shared definitions for the write-back burst issuer: the FSM state encoding,
// the AXI constants the issuer drives or compares against, and helpers that
// derive burst geometry from the module parameters.
// ---------------------------------------------------------------------------
package axi_wr_back_burst_issuer_pkg;

   // Burst sequencing: wait for data, address phase, data phase, response.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AW   = 2'd1,
      ST_W    = 2'd2,
      ST_B    = 2'd3
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // Beat counters must hold values up to 256 (the longest AXI4 INCR burst).
   localparam int unsigned LEN_W = 9;

   // Bytes covered by one full burst.
   function automatic int unsigned calc_burst_bytes(input int unsigned beats,
                                                    input int unsigned data_width);
      return beats * (data_width / 8);
   endfunction

   // AXI AxSIZE encoding: log2 of the bytes per beat.
   function automatic logic [2:0] calc_awsize(input int unsigned data_width);
      int unsigned bytes;
      logic [2:0]  size;
      bytes = data_width / 8;
      size  = '0;
      for (int i = 0; i < 8; i++) begin
         if ((32'd1 << i) == bytes) size = 3'(i);
      end
      return size;
   endfunction

endpackage

// File: rtl/axi_wr_back_burst_issuer_skid_buf.sv
// ---------------------------------------------------------------------------
// wr_back_skid_buf
// Two-entry valid/ready buffer sitting behind a read port with one cycle of
// read latency (a FIFO read side). The caller asserts rd_req_i when it pops
// the source; the data appearing on rd_data_i the following cycle is captured
// here. space_o tells the caller it may issue another pop this cycle without
// ever overflowing, while still sustaining one beat per cycle downstream.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rd_req_i          a pop was issued to the source this cycle
//   rd_data_i         source data, valid the cycle after rd_req_i
//   out_valid_o       buffer holds at least one entry
//   out_data_o        oldest entry
//   out_ready_i       downstream consumes the head when out_valid_o is set
//   space_o           another pop may be issued this cycle
// ---------------------------------------------------------------------------
module wr_back_skid_buf #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rd_req_i,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   input  logic                  out_ready_i,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  space_o
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic                  inflight_q;
   logic                  push;
   logic                  pop;
   logic [2:0]            occupancy;

   assign push        = inflight_q;
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign pop         = out_valid_o && out_ready_i;

   // Entries that will exist once this cycle settles: what is stored, plus the
   // word already on its way from the source, minus the head leaving now.
   // Counting the departing head is what lets a pop go out every cycle while
   // the downstream side keeps accepting.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign space_o   = (occupancy < 3'd2);

   // Storage has no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= rd_data_i;
   end

   // Pointer and occupancy bookkeeping; a pop issued last cycle lands now.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_req_i;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/axi_wr_back_burst_issuer.sv
// ---------------------------------------------------------------------------
// axi_wr_back_burst_issuer
// Drains the read side of the write-back FIFO into memory as AXI4 INCR write
// bursts, one burst outstanding at a time, walking a ring of addresses
// [BASE_ADDR, BASE_ADDR+WINDOW_BYTES). Runs entirely in the FIFO read clock.
//
// Ports:
//   rclk, rrst               FIFO read clock, synchronous active-high reset
//   enable, flush            start gating; flush allows a short final burst
//   rd_water_level, rempty   FIFO read-side occupancy and empty flag
//   r_en, rdata              FIFO pop and data (data one cycle after pop)
//   m_axi_aw*                write address channel
//   m_axi_w*                 write data channel
//   m_axi_b*                 write response channel
//   busy                     a burst is in progress
//   resp_err                 sticky: a non-OKAY response was seen
//   burst_cnt                completed bursts, wrapping
// ---------------------------------------------------------------------------
module axi_wr_back_burst_issuer
   import axi_wr_back_burst_issuer_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           DEPTH_WIDTH  = 9,
   parameter int unsigned           BURST_LEN    = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int unsigned           WINDOW_BYTES = 65536
) (
   input  logic                    rclk,
   input  logic                    rrst,
   input  logic                    enable,
   input  logic                    flush,
   input  logic [DEPTH_WIDTH:0]    rd_water_level,
   input  logic                    rempty,
   output logic                    r_en,
   input  logic [DATA_WIDTH-1:0]   rdata,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic                    busy,
   output logic                    resp_err,
   output logic [31:0]             burst_cnt
);

   localparam int unsigned           BURST_BYTES = calc_burst_bytes(BURST_LEN, DATA_WIDTH);
   localparam logic [2:0]            AWSIZE      = calc_awsize(DATA_WIDTH);
   localparam logic [ADDR_WIDTH:0]   WINDOW_END  = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(WINDOW_BYTES);
   localparam logic [DEPTH_WIDTH:0]  FULL_LEVEL  = (DEPTH_WIDTH+1)'(BURST_LEN);
   localparam logic [LEN_W-1:0]      FULL_LEN    = LEN_W'(BURST_LEN);

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      popped_q, popped_d;
   logic [LEN_W-1:0]      beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic                  resp_err_q, resp_err_d;
   logic [31:0]           burst_cnt_q, burst_cnt_d;

   logic                  buf_valid;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  buf_space;
   logic                  buf_ready;
   logic                  rd_req;
   logic                  w_fire;
   logic                  last_beat;
   logic [ADDR_WIDTH:0]   next_addr;

   wr_back_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk_i       (rclk),
      .rst_i       (rrst),
      .rd_req_i    (rd_req),
      .rd_data_i   (rdata),
      .out_ready_i (buf_ready),
      .out_valid_o (buf_valid),
      .out_data_o  (buf_data),
      .space_o     (buf_space)
   );

   assign buf_ready = m_axi_wready && (state_q == ST_W);
   assign w_fire    = m_axi_wvalid && m_axi_wready;
   assign last_beat = (beat_q == len_q - LEN_W'(1));

   // One extra bit so the end-of-window compare cannot be fooled by overflow.
   assign next_addr = {1'b0, awaddr_q} + (ADDR_WIDTH+1)'(BURST_BYTES);

   assign r_en          = rd_req;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = 8'(len_q - LEN_W'(1));
   assign m_axi_awsize  = AWSIZE;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_wvalid  = (state_q == ST_W) && buf_valid;
   assign m_axi_wdata   = buf_data;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = m_axi_wvalid && last_beat;
   assign busy          = (state_q != ST_IDLE);
   assign resp_err      = resp_err_q;
   assign burst_cnt     = burst_cnt_q;

   // Burst sequencing. The IDLE decision uses the registered water level, so
   // returning to IDLE for a cycle after every burst lets the level catch up
   // with the pops just made. Every burst, full or partial, advances the
   // address by a whole burst so bursts stay aligned and never cross 4 KB.
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      popped_d      = popped_q;
      beat_d        = beat_q;
      awaddr_d      = awaddr_q;
      resp_err_d    = resp_err_q;
      burst_cnt_d   = burst_cnt_q;
      rd_req        = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_bready  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            popped_d = '0;
            beat_d   = '0;
            if (enable && (rd_water_level >= FULL_LEVEL)) begin
               len_d   = FULL_LEN;
               state_d = ST_AW;
            end else if (enable && flush && (rd_water_level != '0)) begin
               len_d   = LEN_W'(rd_water_level);
               state_d = ST_AW;
            end
         end
         ST_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_d = ST_W;
         end
         ST_W: begin
            rd_req = (popped_q < len_q) && !rempty && buf_space;
            if (rd_req) popped_d = popped_q + LEN_W'(1);
            if (w_fire) begin
               beat_d = beat_q + LEN_W'(1);
               if (last_beat) state_d = ST_B;
            end
         end
         ST_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               if (m_axi_bresp != RESP_OKAY) resp_err_d = 1'b1;
               burst_cnt_d = burst_cnt_q + 32'd1;
               awaddr_d    = (next_addr >= WINDOW_END) ? BASE_ADDR : next_addr[ADDR_WIDTH-1:0];
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register. A reset in mid-burst simply abandons it; the FIFO is
   // expected to be reset in the same event so no stale words remain.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q     <= ST_IDLE;
         len_q       <= LEN_W'(1);
         popped_q    <= '0;
         beat_q      <= '0;
         awaddr_q    <= BASE_ADDR;
         resp_err_q  <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         popped_q    <= popped_d;
         beat_q      <= beat_d;
         awaddr_q    <= awaddr_d;
         resp_err_q  <= resp_err_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule
